narnet_compute_units: RTL and testbench
=======================================

# narnet_compute_units

Arithmetic core of the NAR-Net inference pipeline: a fixed-point multiply-accumulate neuron (neuron_v2 function), a saturating scalar accumulator (accumulator function) and a tanh lookup table (tanh_lut function). All three are packaged in one block. The block sits between the network controller FSM and the weight ROM. The controller drives weights, inputs and biases, and reads neuron sums, activations and the final output sum.

## Interface
- N, 16, total word width (signed two's complement).
- Q, 10, fractional bits; Q ≥ 5 and Q ≤ N−2.

- clk  in  1  single clock; everything is posedge.
- rst  in  1  asynchronous, active-low reset.
- n_clr  in  1  synchronous clear of the neuron running sum.
- n_valid  in  1  neuron input strobe; the product is accumulated on every edge where it is 1.
- n_w  in  N  signed weight.
- n_x  in  N  signed input.
- n_b  in  N  signed bias.
- n_out  out  N  signed neuron result, equal to sat(sum + n_b).
- acc_clr  in  1  synchronous clear of the accumulator.
- acc_add  in  1  add strobe.
- acc_a  in  N  signed addend.
- acc_out  out  N  registered accumulator value.
- t_addr  in  N  signed tanh argument.
- t_out  out  N  registered tanh(t_addr).

## Operation
- Format: all values are signed N-bit with Q fractional bits (N=16, Q=10 gives 1.0 = 1024).
- sat(v) clamps to [−2^(N−1), 2^(N−1)−1].
- Product: 2N-bit signed n_w*n_x, arithmetic-shifted right by Q (floor), then saturated to N bits.
- Neuron:
  - Holds a registered running sum S.
  - If n_clr=1: S ← 0. n_clr has priority over n_valid.
  - Else if n_valid=1: S ← sat(S + product).
  - n_out = sat(S + n_b), combinational from S and n_b.
  - Bias may change at any time and takes effect immediately.
- Accumulator:
  - If acc_clr=1: acc_out ← 0 (priority).
  - Else if acc_add=1: acc_out ← sat(acc_out + acc_a).
  - Else hold.
  - The sum is computed at N+1 bits before saturation.
- tanh LUT:
  - Odd-symmetric; a 128-entry magnitude table.
  - m = |t_addr|, saturated (−2^(N−1) maps to 2^(N−1)−1).
  - idx = min(m >> (Q−5), 127), i.e. step 1/32 covering [0,4).
  - T[idx] = round(tanh(idx/32)·2^Q) for idx < 127; T[127] = round(tanh(4)·2^Q). T[0] = 0.
  - Any m ≥ 4.0 therefore returns T[127] (1023 at Q=10).
  - t_out ← T[idx] if t_addr ≥ 0, else −T[idx].
  - Table contents are computed at elaboration from N and Q.
- Reset (rst=0, asynchronous): S=0, acc_out=0, t_out=0. n_out then equals sat(n_b).

## Timing
- Neuron:
  - n_valid sampled at edge k; n_out reflects the new S after edge k.
  - Holding n_valid for M cycles accumulates M products.
  - A 16-term dot product needs 16 strobes after one n_clr cycle.
- Accumulator: acc_out is updated one cycle after acc_add is sampled. Summing 5 terms needs 5 consecutive add cycles.
- tanh: t_out is valid one cycle after t_addr is presented. It is fully pipelined: a new address every cycle gives one result per cycle.
- Simultaneous clr and valid/add: the clear wins, and that cycle's input is discarded.
- Reset mid-operation: all state is cleared immediately, asynchronously. Operation resumes on the first edge after rst returns high.
- Wrap-around never occurs; every add saturates.

## Test plan
- Neuron MAC: n_clr one cycle, n_b=256; strobe w=1024,x=512 -> n_out=768. Next strobe w=−1024,x=256 -> n_out=512. Holding n_clr -> n_out=256.
- Neuron saturation: w=32767, x=32767, 3 strobes, b=0 -> n_out=32767. Negative case w=−32768, x=32767 -> n_out=−32768.
- Accumulator: acc_clr, then add 100, 200, −50 on consecutive cycles -> acc_out 100, 300, 250. Add 32767 twice -> 32767. acc_clr together with acc_add -> 0.
- tanh values: t_addr 0 -> 0; 512 -> 473; 1024 -> 780; −1024 -> −780; 8192 -> 1023; −32768 -> −1023. Back-to-back addresses give one result per cycle with 1-cycle latency.
- Reset: assert rst low mid-accumulation (S=768, acc_out=300, t_out=780) -> all three cleared without a clock edge; n_out=n_b; normal operation resumes after release.

Source files
------------

// File: rtl/narnet_compute_units.sv
// narnet_compute_units: arithmetic core of the NAR-Net inference pipeline.
// Holds a fixed-point MAC neuron, a saturating scalar accumulator and a
// registered, odd-symmetric tanh lookup. All values are signed N-bit with
// Q fractional bits; every addition saturates instead of wrapping.
module narnet_compute_units #(
   parameter int N = 16,
   parameter int Q = 10
) (
   input  logic                clk,
   input  logic                rst,
   // neuron
   input  logic                n_clr,
   input  logic                n_valid,
   input  logic signed [N-1:0] n_w,
   input  logic signed [N-1:0] n_x,
   input  logic signed [N-1:0] n_b,
   output logic signed [N-1:0] n_out,
   // accumulator
   input  logic                acc_clr,
   input  logic                acc_add,
   input  logic signed [N-1:0] acc_a,
   output logic signed [N-1:0] acc_out,
   // tanh lookup
   input  logic signed [N-1:0] t_addr,
   output logic signed [N-1:0] t_out
);

   localparam logic signed [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
   localparam logic signed [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

   // Clamp an N+1-bit sum to N bits: overflow shows as the top two bits differing.
   function automatic logic signed [N-1:0] sat_n1(input logic signed [N:0] v);
      if (v[N] != v[N-1]) return v[N] ? MIN_V : MAX_V;
      return v[N-1:0];
   endfunction

   // Clamp a 2N-bit value to N bits: in range only if bits [2N-1:N-1] all agree.
   function automatic logic signed [N-1:0] sat_2n(input logic signed [2*N-1:0] v);
      logic [N:0] top;
      top = v[2*N-1:N-1];
      if ((&top) || !(|top)) return v[N-1:0];
      return v[2*N-1] ? MIN_V : MAX_V;
   endfunction

   // ------------------------------------------------------------------
   // Neuron
   // ------------------------------------------------------------------
   logic signed [2*N-1:0] prod_full;
   logic signed [2*N-1:0] prod_sh;
   logic signed [N-1:0]   prod;
   logic signed [N:0]     s_sum;
   logic signed [N-1:0]   s_q;

   // Full-precision product, floor-shifted back to Q fractional bits, then clamped.
   always_comb begin
      prod_full = $signed({{N{n_w[N-1]}}, n_w}) * $signed({{N{n_x[N-1]}}, n_x});
      prod_sh   = prod_full >>> Q;
      prod      = sat_2n(prod_sh);
      s_sum     = {s_q[N-1], s_q} + {prod[N-1], prod};
      n_out     = sat_n1({s_q[N-1], s_q} + {n_b[N-1], n_b});
   end

   // Running sum: clear beats the accumulate strobe.
   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         s_q <= '0;
      else if (n_clr)   s_q <= '0;
      else if (n_valid) s_q <= sat_n1(s_sum);
   end

   // ------------------------------------------------------------------
   // Accumulator
   // ------------------------------------------------------------------
   logic signed [N:0] acc_sum;

   // Sum carried at N+1 bits so overflow can be detected before clamping.
   always_comb begin
      acc_sum = {acc_out[N-1], acc_out} + {acc_a[N-1], acc_a};
   end

   // Accumulator register: clear beats add, otherwise hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         acc_out <= '0;
      else if (acc_clr) acc_out <= '0;
      else if (acc_add) acc_out <= sat_n1(acc_sum);
   end

   // ------------------------------------------------------------------
   // tanh lookup
   // ------------------------------------------------------------------
   logic signed [N-1:0] t_rom [128];
   logic [N-1:0]        mag;
   logic [N-1:0]        shifted;
   logic [6:0]          idx;
   logic signed [N-1:0] t_val;

   // Magnitude table built at elaboration: step 1/32, last entry pinned to tanh(4).
   for (genvar i = 0; i < 128; i++) begin : g_rom
      localparam real XR = (i == 127) ? 4.0 : i / 32.0;
      localparam real TR = 1.0 - 2.0 / ($exp(2.0 * XR) + 1.0);
      localparam int  TV = $rtoi(TR * (2.0 ** Q) + 0.5);
      assign t_rom[i] = N'(TV);
   end

   // Saturated magnitude -> clamped index -> sign restored.
   // NOTE: every always_comb output is assigned on all paths so no latch is inferred.
   always_comb begin
      mag = t_addr[N-1] ? N'(-t_addr) : t_addr;
      if (t_addr == MIN_V) mag = MAX_V;
      shifted = mag >> (Q - 5);
      idx     = (shifted > N'(127)) ? 7'd127 : shifted[6:0];
      t_val   = t_addr[N-1] ? -t_rom[idx] : t_rom[idx];
   end

   // One-cycle registered lookup; a new address every cycle yields a result every cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) t_out <= '0;
      else      t_out <= t_val;
   end

endmodule

// File: tb/tb_narnet_compute_units.sv
// Self-checking bench for narnet_compute_units: table-driven tanh vectors,
// hand-written neuron/accumulator/reset sequences, then randomized traffic
// compared against an arithmetic reference model.
module tb_narnet_compute_units;

   localparam int N = 16;
   localparam int Q = 10;

   logic                clk = 1'b0;
   logic                rst;
   logic                n_clr, n_valid;
   logic signed [N-1:0] n_w, n_x, n_b, n_out;
   logic                acc_clr, acc_add;
   logic signed [N-1:0] acc_a, acc_out;
   logic signed [N-1:0] t_addr, t_out;

   int n_cmp  = 0;
   int n_fail = 0;

   narnet_compute_units #(.N(N), .Q(Q)) dut (
      .clk(clk), .rst(rst),
      .n_clr(n_clr), .n_valid(n_valid), .n_w(n_w), .n_x(n_x), .n_b(n_b), .n_out(n_out),
      .acc_clr(acc_clr), .acc_add(acc_add), .acc_a(acc_a), .acc_out(acc_out),
      .t_addr(t_addr), .t_out(t_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int exp_val;
   } tanh_vec_t;

   task automatic check(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   // tanh from its exponential definition, quantised as the table defines it.
   function automatic int tanh_ref(input int a);
      int  m, idx, v;
      real x, ep, en;
      m = (a < 0) ? -a : a;
      if (m > 32767) m = 32767;
      idx = m / (1 << (Q - 5));
      if (idx > 127) idx = 127;
      x  = (idx == 127) ? 4.0 : idx / 32.0;
      ep = $exp(x);
      en = $exp(-x);
      v  = $rtoi((ep - en) / (ep + en) * 1024.0 + 0.5);
      return (a < 0) ? -v : v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      tanh_vec_t tv[10];
      int s_m, acc_m, t_m;
      int w, x, b, a, ta, cl, va, ac, ad;
      longint p;

      tv[0] = '{0, 0};        tv[1] = '{512, 473};     tv[2] = '{1024, 780};
      tv[3] = '{-1024, -780}; tv[4] = '{8192, 1023};   tv[5] = '{-32768, -1023};
      tv[6] = '{32, 32};      tv[7] = '{4095, 1023};   tv[8] = '{32767, 1023};
      tv[9] = '{-1, 0};

      rst = 1'b0; n_clr = 0; n_valid = 0; n_w = 0; n_x = 0; n_b = 0;
      acc_clr = 0; acc_add = 0; acc_a = 0; t_addr = 0;
      #12;
      check("reset_n_out", n_out, 0);
      check("reset_acc", acc_out, 0);
      check("reset_t", t_out, 0);
      @(negedge clk);
      rst = 1'b1;
      step();

      // tanh table, back-to-back addresses: each result one cycle after its address
      for (int i = 0; i < 10; i++) begin
         t_addr = N'(tv[i].addr);
         step();
         check($sformatf("tanh[%0d]", tv[i].addr), t_out, tv[i].exp_val);
      end

      // Neuron MAC
      n_clr = 1; n_b = 256; step();
      check("mac_clr", n_out, 256);
      n_clr = 0; n_valid = 1; n_w = 1024; n_x = 512; step();
      check("mac_1", n_out, 768);
      n_w = -1024; n_x = 256; step();
      check("mac_2", n_out, 512);
      n_valid = 0; n_clr = 1; step();
      check("mac_hold_clr", n_out, 256);
      n_b = -100; #1;
      check("bias_immediate", n_out, -100);

      // Neuron saturation
      n_b = 0; step();
      n_clr = 0; n_valid = 1; n_w = 32767; n_x = 32767;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("sat_pos_%0d", i), n_out, 32767);
      end
      n_valid = 0; n_clr = 1; step();
      n_clr = 0; n_valid = 1; n_w = -32768; n_x = 32767; step();
      check("sat_neg", n_out, -32768);
      n_clr = 1; step();
      check("clr_beats_valid", n_out, 0);
      n_clr = 0; n_valid = 0;

      // Accumulator
      acc_clr = 1; step();
      acc_clr = 0; acc_add = 1;
      acc_a = 100; step(); check("acc_100", acc_out, 100);
      acc_a = 200; step(); check("acc_300", acc_out, 300);
      acc_a = -50; step(); check("acc_250", acc_out, 250);
      acc_add = 0; acc_a = 999; step(); check("acc_hold", acc_out, 250);
      acc_clr = 1; step(); acc_clr = 0; acc_add = 1; acc_a = 32767;
      step(); step(); check("acc_sat_pos", acc_out, 32767);
      acc_clr = 1; step(); check("acc_clr_beats_add", acc_out, 0);
      acc_clr = 0; acc_a = -32768;
      step(); step(); check("acc_sat_neg", acc_out, -32768);
      acc_add = 0; acc_clr = 1; step(); acc_clr = 0;

      // Asynchronous reset mid-operation
      n_clr = 1; n_b = 256; step();
      n_clr = 0; n_valid = 1; n_w = 1024; n_x = 768;
      acc_add = 1; acc_a = 100; t_addr = 1024; step();
      n_valid = 0; acc_a = 200; step();
      acc_add = 0;
      check("pre_rst_n", n_out, 1024);
      check("pre_rst_acc", acc_out, 300);
      check("pre_rst_t", t_out, 780);
      #2 rst = 1'b0; #1;
      check("async_rst_n", n_out, 256);
      check("async_rst_acc", acc_out, 0);
      check("async_rst_t", t_out, 0);
      t_addr = 512; n_valid = 1; n_w = 1024; n_x = 1024; acc_add = 1; acc_a = 5;
      step();
      check("in_rst_t", t_out, 0);
      #2 rst = 1'b1;
      step();
      check("resume_n", n_out, 1280);
      check("resume_acc", acc_out, 5);
      check("resume_t", t_out, 473);

      // Randomized traffic against the reference model
      n_valid = 0; acc_add = 0; n_clr = 1; acc_clr = 1; t_addr = 0; step();
      s_m = 0; acc_m = 0; t_m = 0;
      for (int i = 0; i < 400; i++) begin
         cl = ($urandom_range(0, 15) == 0);
         va = ($urandom_range(0, 3) != 0);
         ac = ($urandom_range(0, 15) == 0);
         ad = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1)) begin
            w = int'($urandom_range(0, 65535)) - 32768;
            x = int'($urandom_range(0, 65535)) - 32768;
         end else begin
            w = int'($urandom_range(0, 4095)) - 2048;
            x = int'($urandom_range(0, 4095)) - 2048;
         end
         b  = int'($urandom_range(0, 65535)) - 32768;
         a  = $urandom_range(0, 1) ? int'($urandom_range(0, 65535)) - 32768
                                   : int'($urandom_range(0, 2047)) - 1024;
         ta = $urandom_range(0, 1) ? int'($urandom_range(0, 65535)) - 32768
                                   : int'($urandom_range(0, 8191)) - 4096;
         n_clr = cl[0]; n_valid = va[0]; n_w = N'(w); n_x = N'(x); n_b = N'(b);
         acc_clr = ac[0]; acc_add = ad[0]; acc_a = N'(a); t_addr = N'(ta);
         step();
         p = (longint'(w) * longint'(x)) >>> Q;
         if (cl != 0)      s_m = 0;
         else if (va != 0) s_m = sat(longint'(s_m) + longint'(sat(p)));
         if (ac != 0)      acc_m = 0;
         else if (ad != 0) acc_m = sat(longint'(acc_m) + longint'(a));
         t_m = tanh_ref(ta);
         check($sformatf("rnd_n_%0d", i), n_out, sat(longint'(s_m) + longint'(b)));
         check($sformatf("rnd_acc_%0d", i), acc_out, acc_m);
         check($sformatf("rnd_t_%0d", i), t_out, t_m);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
